// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and defaults used by the program-counter unit.
package cpu_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0080;

  // Wide enough for the full 0..15 boot-delay range.
  localparam int BOOT_CNT_W = 4;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational fixed-priority next-PC selector: trap > trap_return > jump > branch > stall > PC+INC.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned jump/branch targets into traps.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int               XLEN        = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEFAULT),
  parameter int               INC         = 4
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            trap_i,
  input  logic            trap_return_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            epc_we_o,
  output logic            trap_set_o,
  output logic            trap_clr_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            misaligned_o
`endif
);

  always_comb begin
    next_pc_o  = pc_i + XLEN'(INC);
    epc_we_o   = 1'b0;
    trap_set_o = 1'b0;
    trap_clr_o = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misaligned_o = 1'b0;
`endif
    if (trap_i) begin
      next_pc_o  = TRAP_VECTOR;
      epc_we_o   = 1'b1;
      trap_set_o = 1'b1;
    end else if (trap_return_i) begin
      next_pc_o  = epc_i;
      trap_clr_o = 1'b1;
    end else if (jump_i) begin
      next_pc_o = jump_target_i;
`ifdef PC_ALIGN_CHECK_EN
      if (jump_target_i[1:0] != 2'b00) begin
        next_pc_o    = TRAP_VECTOR;
        epc_we_o     = 1'b1;
        trap_set_o   = 1'b1;
        misaligned_o = 1'b1;
      end
`endif
    end else if (branch_taken_i) begin
      next_pc_o = branch_target_i;
`ifdef PC_ALIGN_CHECK_EN
      if (branch_target_i[1:0] != 2'b00) begin
        next_pc_o    = TRAP_VECTOR;
        epc_we_o     = 1'b1;
        trap_set_o   = 1'b1;
        misaligned_o = 1'b1;
      end
`endif
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot-delay FSM, fetch PC, exception PC and trap flag.
// Optional macro PC_ALIGN_CHECK_EN adds misaligned-target trapping and the misaligned output.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int               XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
  parameter int               INC          = 4,
  parameter int               BOOT_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic            trap_return,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_plus,
  output logic [XLEN-1:0] epc,
  output logic            fetch_valid,
  output logic            in_trap
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            misaligned
`endif
);

  pc_state_t              state_q, state_d;
  logic [BOOT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        epc_q, epc_d;
  logic                   in_trap_q, in_trap_d;

  logic [XLEN-1:0]        mux_next_pc;
  logic                   mux_epc_we;
  logic                   mux_trap_set;
  logic                   mux_trap_clr;

`ifdef PC_ALIGN_CHECK_EN
  logic                   mux_misaligned;
  logic                   mis_q, mis_d;
`endif

  pc_next_mux #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INC         (INC)
  ) u_next_mux (
    .pc_i            (pc_q),
    .epc_i           (epc_q),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .trap_i          (trap),
    .trap_return_i   (trap_return),
    .next_pc_o       (mux_next_pc),
    .epc_we_o        (mux_epc_we),
    .trap_set_o      (mux_trap_set),
    .trap_clr_o      (mux_trap_clr)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misaligned_o    (mux_misaligned)
`endif
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    in_trap_d = in_trap_q;
`ifdef PC_ALIGN_CHECK_EN
    mis_d     = 1'b0;
`endif
    case (state_q)
      BOOT: begin
        // PC is frozen and every control input is ignored until the delay expires.
        if (cnt_q == BOOT_CNT_W'(BOOT_CYCLES)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        pc_d = mux_next_pc;
        if (mux_epc_we) begin
          epc_d = pc_q;
        end
        if (mux_trap_set) begin
          in_trap_d = 1'b1;
        end else if (mux_trap_clr) begin
          in_trap_d = 1'b0;
        end
`ifdef PC_ALIGN_CHECK_EN
        mis_d = mux_misaligned;
`endif
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BOOT;
      cnt_q     <= '0;
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      in_trap_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      in_trap_q <= in_trap_d;
`ifdef PC_ALIGN_CHECK_EN
      mis_q     <= mis_d;
`endif
    end
  end

  assign PC          = pc_q;
  assign PC_plus     = pc_q + XLEN'(INC);
  assign epc         = epc_q;
  assign in_trap     = in_trap_q;
  assign fetch_valid = (state_q == RUN);
`ifdef PC_ALIGN_CHECK_EN
  assign misaligned  = mis_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: each driven cycle queues its expected post-edge state.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        trap;
  logic        trap_return;
  logic [31:0] PC;
  logic [31:0] PC_plus;
  logic [31:0] epc;
  logic        fetch_valid;
  logic        in_trap;
`ifdef PC_ALIGN_CHECK_EN
  logic        misaligned;
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        in_trap;
    logic        fv;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0080),
    .INC          (4),
    .BOOT_CYCLES  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .trap          (trap),
    .trap_return   (trap_return),
    .PC            (PC),
    .PC_plus       (PC_plus),
    .epc           (epc),
    .fetch_valid   (fetch_valid),
    .in_trap       (in_trap)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misaligned    (misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show after the next edge.
  task automatic step(input string tag, input logic rst, input logic stl,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic tr, input logic trr,
                      input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic e_trap, input logic e_fv, input logic e_mis);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt; trap = tr; trap_return = trr;
    e.tag = tag; e.pc = e_pc; e.epc = e_epc; e.in_trap = e_trap; e.fv = e_fv; e.mis = e_mis;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq({e.tag, ".pc"}, PC, e.pc);
        check_eq({e.tag, ".pc_plus"}, PC_plus, e.pc + 32'd4);
        check_eq({e.tag, ".epc"}, epc, e.epc);
        check_eq({e.tag, ".in_trap"}, {31'd0, in_trap}, {31'd0, e.in_trap});
        check_eq({e.tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e.fv});
`ifdef PC_ALIGN_CHECK_EN
        check_eq({e.tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
`endif
        $display("cycle %-14s PC=%08h epc=%08h in_trap=%0b fv=%0b", e.tag, PC, epc, in_trap, fetch_valid);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; trap = 1'b0; trap_return = 1'b0;

    //    tag            rst stl br bt            jp jt            tr trr  pc            epc           it fv mis
    step("reset0",       1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000000, 32'h00000000, 0, 0, 0);
    step("reset1",       1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000000, 32'h00000000, 0, 0, 0);
    step("boot1",        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000000, 32'h00000000, 0, 0, 0);
    step("boot2_ignore", 0, 1, 1, 32'h200,      1, 32'h100,      1, 0, 32'h00000000, 32'h00000000, 0, 0, 0);
    step("run_first",    0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000000, 32'h00000000, 0, 1, 0);
    step("seq4",         0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000004, 32'h00000000, 0, 1, 0);
    step("seq8",         0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000008, 32'h00000000, 0, 1, 0);
    step("jump10",       0, 0, 0, 32'h0,        1, 32'h10,       0, 0, 32'h00000010, 32'h00000000, 0, 1, 0);
    step("stall",        0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000010, 32'h00000000, 0, 1, 0);
    step("stall_branch", 0, 1, 1, 32'h40,       0, 32'h0,        0, 0, 32'h00000040, 32'h00000000, 0, 1, 0);
    step("jump20",       0, 0, 0, 32'h0,        1, 32'h20,       0, 0, 32'h00000020, 32'h00000000, 0, 1, 0);
    step("jump_vs_br",   0, 0, 1, 32'h200,      1, 32'h100,      0, 0, 32'h00000100, 32'h00000000, 0, 1, 0);
    step("jump30",       0, 0, 0, 32'h0,        1, 32'h30,       0, 0, 32'h00000030, 32'h00000000, 0, 1, 0);
    step("trap",         0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h00000080, 32'h00000030, 1, 1, 0);
    step("in_handler",   0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000084, 32'h00000030, 1, 1, 0);
    step("trap_nested",  0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h00000080, 32'h00000084, 1, 1, 0);
    step("tret_vs_jump", 0, 0, 0, 32'h0,        1, 32'h200,      0, 1, 32'h00000084, 32'h00000084, 0, 1, 0);
    step("seq88",        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000088, 32'h00000084, 0, 1, 0);
    step("tret_notrap",  0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h00000084, 32'h00000084, 0, 1, 0);
    step("trap_vs_all",  0, 1, 1, 32'h300,      1, 32'h400,      1, 1, 32'h00000080, 32'h00000084, 1, 1, 0);
    step("tret",         0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h00000084, 32'h00000084, 0, 1, 0);
    step("jump_top",     0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 32'h00000084, 0, 1, 0);
    step("wrap",         0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000000, 32'h00000084, 0, 1, 0);
    step("jump50",       0, 0, 0, 32'h0,        1, 32'h50,       0, 0, 32'h00000050, 32'h00000084, 0, 1, 0);
    if (ALIGN) begin
      step("jump_misal", 0, 0, 0, 32'h0,        1, 32'h102,      0, 0, 32'h00000080, 32'h00000050, 1, 1, 1);
      step("misal_pulse",0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000084, 32'h00000050, 1, 1, 0);
    end else begin
      step("jump_unal",  0, 0, 0, 32'h0,        1, 32'h102,      0, 0, 32'h00000102, 32'h00000084, 0, 1, 0);
      step("seq_unal",   0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000106, 32'h00000084, 0, 1, 0);
    end
    step("branch_end",   0, 0, 1, 32'h1000,     0, 32'h0,        0, 0, 32'h00001000, ALIGN ? 32'h00000050 : 32'h00000084, ALIGN, 1, 0);
    step("reset_mid",    1, 0, 0, 32'h0,        1, 32'h500,      1, 0, 32'h00000000, 32'h00000000, 0, 0, 0);
    step("reboot1",      0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000000, 32'h00000000, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
